// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, sequences requests to the instruction ROM
// and hands each fetched word (with its PC) to decode over a valid/ready handshake.
module instr_fetch_unit #(
    parameter int                 WORD_SIZE      = 32,
    parameter int                 ADDRESS_SIZE   = 16,
    parameter int                 PC_SIZE        = 32,
    parameter logic [PC_SIZE-1:0] RESET_PC       = '0,
    parameter int                 TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_enable,
    output logic [ADDRESS_SIZE-1:0] imem_address,
    input  logic [WORD_SIZE-1:0]    imem_data,
    input  logic                    imem_data_ready,
    input  logic                    redirect_valid,
    input  logic [PC_SIZE-1:0]      redirect_pc,
    output logic                    if_valid,
    input  logic                    if_ready,
    output logic [WORD_SIZE-1:0]    if_instr,
    output logic [PC_SIZE-1:0]      if_pc,
    output logic [PC_SIZE-1:0]      if_npc,
    output logic                    misaligned,
    output logic                    fetch_error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t               r_state;
    logic [PC_SIZE-1:0]   r_pc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_valid;
    logic [WORD_SIZE-1:0] r_instr;
    logic [PC_SIZE-1:0]   r_if_pc;
    logic [PC_SIZE-1:0]   r_if_npc;
    logic                 r_mis;
    logic                 r_err;

    logic                 w_redirect;
    logic [PC_SIZE-1:0]   w_redirect_pc;
    logic [PC_SIZE-1:0]   w_pc_plus4;

    // A dead fetch unit stays dead: redirects are ignored once in ERROR.
    assign w_redirect    = redirect_valid && (r_state != S_ERROR);
    assign w_redirect_pc = {redirect_pc[PC_SIZE-1:2], 2'b00};
    assign w_pc_plus4    = r_pc + PC_SIZE'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_REQ;
            r_pc     <= RESET_PC;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_instr  <= '0;
            r_if_pc  <= '0;
            r_if_npc <= '0;
            r_mis    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_mis <= w_redirect && (redirect_pc[1:0] != 2'b00);
            if (w_redirect) begin
                // Any response still in flight for the old PC is simply dropped.
                r_pc    <= w_redirect_pc;
                r_state <= S_REQ;
                r_valid <= 1'b0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_REQ: begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                    end
                    S_WAIT: begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (imem_data_ready) begin
                            r_instr  <= imem_data;
                            r_if_pc  <= r_pc;
                            r_if_npc <= w_pc_plus4;
                            r_valid  <= 1'b1;
                            r_state  <= S_HOLD;
                        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            r_state <= S_ERROR;
                            r_err   <= 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (if_ready) begin
                            r_pc    <= w_pc_plus4;
                            r_valid <= 1'b0;
                            r_state <= S_REQ;
                        end
                    end
                    S_ERROR: begin
                        r_valid <= 1'b0;
                    end
                    default: begin
                        r_state <= S_REQ;
                    end
                endcase
            end
        end
    end

    assign imem_enable  = !rst && ((r_state == S_REQ) || (r_state == S_WAIT));
    assign imem_address = r_pc[ADDRESS_SIZE+1:2];
    assign if_valid     = r_valid;
    assign if_instr     = r_instr;
    assign if_pc        = r_if_pc;
    assign if_npc       = r_if_npc;
    assign misaligned   = r_mis;
    assign fetch_error  = r_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: variable-latency ROM model, transaction-level PC
// predictor, directed scenarios plus a randomized handshake/redirect phase.
module tb_instr_fetch_unit;

    localparam int WS = 32;
    localparam int AW = 16;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          imem_enable;
    logic [AW-1:0] imem_address;
    logic [WS-1:0] imem_data;
    logic          imem_data_ready;
    logic          redirect_valid;
    logic [PW-1:0] redirect_pc;
    logic          if_valid;
    logic          if_ready;
    logic [WS-1:0] if_instr;
    logic [PW-1:0] if_pc;
    logic [PW-1:0] if_npc;
    logic          misaligned;
    logic          fetch_error;

    logic          w_imem_enable;
    logic [AW-1:0] w_imem_address;
    logic [WS-1:0] w_imem_data;
    logic          w_imem_data_ready;
    logic          w_if_valid;
    logic [WS-1:0] w_if_instr;
    logic [PW-1:0] w_if_pc;
    logic [PW-1:0] w_if_npc;
    logic          w_misaligned;
    logic          w_fetch_error;

    int n_tests    = 0;
    int n_fail     = 0;
    int xfer_count = 0;
    bit mon_en     = 1'b1;

    always #5 clk = ~clk;

    instr_fetch_unit #(.WORD_SIZE(WS), .ADDRESS_SIZE(AW), .PC_SIZE(PW),
                       .RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .imem_enable(imem_enable), .imem_address(imem_address),
        .imem_data(imem_data), .imem_data_ready(imem_data_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .if_npc(if_npc),
        .misaligned(misaligned), .fetch_error(fetch_error)
    );

    instr_fetch_unit #(.WORD_SIZE(WS), .ADDRESS_SIZE(AW), .PC_SIZE(PW),
                       .RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(16)) dut_w (
        .clk(clk), .rst(rst),
        .imem_enable(w_imem_enable), .imem_address(w_imem_address),
        .imem_data(w_imem_data), .imem_data_ready(w_imem_data_ready),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .if_valid(w_if_valid), .if_ready(1'b1), .if_instr(w_if_instr),
        .if_pc(w_if_pc), .if_npc(w_if_npc),
        .misaligned(w_misaligned), .fetch_error(w_fetch_error)
    );

    function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
        case (a)
            16'd0:   rom_word = 32'h2001_0005;
            16'd1:   rom_word = 32'h2002_0007;
            16'd2:   rom_word = 32'h0022_1820;
            16'd3:   rom_word = 32'hAC03_0010;
            default: rom_word = {~a, a};
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ROM model: a new address starts a request that answers after mem_lat cycles.
    int            mem_lat      = 0;
    bit            mem_stall    = 1'b0;
    int            mem_next_lat = 0;
    bit            mem_busy;
    logic [AW-1:0] mem_addr;
    int            mem_rem;
    int            mem_rem_now;
    bit            mem_new;

    always_comb begin
        mem_new     = !mem_busy || (imem_address != mem_addr);
        mem_rem_now = mem_new ? mem_next_lat : mem_rem;
    end

    always @(posedge clk) begin
        mem_next_lat <= (mem_lat < 0) ? int'($urandom_range(0, 4)) : mem_lat;
        if (!imem_enable) begin
            mem_busy        <= 1'b0;
            imem_data_ready <= 1'b0;
            imem_data       <= 'z;
        end else begin
            mem_busy <= 1'b1;
            mem_addr <= imem_address;
            if (mem_stall || mem_rem_now != 0) begin
                imem_data_ready <= 1'b0;
                imem_data       <= 'z;
                mem_rem         <= (mem_rem_now > 0) ? mem_rem_now - 1 : 0;
            end else begin
                imem_data_ready <= 1'b1;
                imem_data       <= rom_word(imem_address);
            end
        end
    end

    always @(posedge clk) begin
        w_imem_data_ready <= w_imem_enable;
        w_imem_data       <= {16'hBEEF, w_imem_address};
    end

    // Transaction-level model: the next word decode should see is at m_exp_pc.
    logic [PW-1:0] m_exp_pc;
    logic          m_prev_valid, m_prev_ready, m_prev_redir, m_prev_mis;
    logic [PW-1:0] m_prev_pc;
    logic [WS-1:0] m_prev_instr;

    always @(negedge clk) begin
        if (rst) begin
            m_exp_pc     <= 32'h0;
            m_prev_valid <= 1'b0;
            m_prev_ready <= 1'b0;
            m_prev_redir <= 1'b0;
            m_prev_mis   <= 1'b0;
        end else if (mon_en) begin
            check_eq("mon_misaligned", misaligned, m_prev_mis);
            if (m_prev_redir) begin
                check_eq("mon_valid_after_redirect", if_valid, 1'b0);
            end else if (m_prev_valid && !m_prev_ready) begin
                check_eq("mon_hold_valid", if_valid, 1'b1);
                check_eq("mon_hold_pc", if_pc, m_prev_pc);
                check_eq("mon_hold_instr", if_instr, m_prev_instr);
            end
            if (if_valid) check_eq("mon_enable_while_valid", imem_enable, 1'b0);
            if (imem_enable) check_eq("mon_address", imem_address, m_exp_pc[AW+1:2]);
            check_eq("mon_fetch_error", fetch_error, 1'b0);
            if (if_valid && if_ready) begin
                check_eq("xfer_pc", if_pc, m_exp_pc);
                check_eq("xfer_instr", if_instr, rom_word(m_exp_pc[AW+1:2]));
                check_eq("xfer_npc", if_npc, m_exp_pc + 32'd4);
                xfer_count <= xfer_count + 1;
                $display("[TB] xfer pc=%08h instr=%08h npc=%08h redirect=%0d",
                         if_pc, if_instr, if_npc, redirect_valid);
            end
            if (redirect_valid)             m_exp_pc <= {redirect_pc[PW-1:2], 2'b00};
            else if (if_valid && if_ready)  m_exp_pc <= m_exp_pc + 32'd4;
            m_prev_valid <= if_valid;
            m_prev_ready <= if_ready;
            m_prev_redir <= redirect_valid;
            m_prev_mis   <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            m_prev_pc    <= if_pc;
            m_prev_instr <= if_instr;
        end
    end

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_if_valid", if_valid, 1'b0);
        check_eq("rst_imem_enable", imem_enable, 1'b0);
        check_eq("rst_misaligned", misaligned, 1'b0);
        check_eq("rst_fetch_error", fetch_error, 1'b0);
        check_eq("rst_if_pc", if_pc, 32'h0);
        check_eq("rst_if_npc", if_npc, 32'h0);
        check_eq("rst_if_instr", if_instr, 32'h0);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!if_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(tag, if_valid, 1'b1);
    endtask

    initial begin
        int n;
        int gap;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b1;

        // Sequential fetch with a zero-wait ROM
        mem_lat = 0;
        do_reset();
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!if_valid && n < 20);
        check_eq("first_valid_edge", n + 1, 3);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                gap = 0;
                do begin
                    @(posedge clk);
                    #1;
                    gap++;
                end while (!if_valid && gap < 20);
                check_eq("seq_gap", gap, 3);
            end
            check_eq("seq_pc", if_pc, 32'(k * 4));
            check_eq("seq_instr", if_instr, rom_word(16'(k)));
        end

        // Backpressure at pc 0x4
        do_reset();
        wait_valid("bp_valid0");
        check_eq("bp_pc0", if_pc, 32'h0);
        @(posedge clk);
        #1;
        if_ready = 1'b0;
        wait_valid("bp_valid1");
        check_eq("bp_pc1", if_pc, 32'h4);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_hold_valid", if_valid, 1'b1);
            check_eq("bp_hold_instr", if_instr, 32'h2002_0007);
            check_eq("bp_hold_enable", imem_enable, 1'b0);
        end
        if_ready = 1'b1;
        @(posedge clk);
        #1;
        wait_valid("bp_valid2");
        check_eq("bp_pc2", if_pc, 32'h8);

        // Redirect while waiting on the ROM for 0x8
        mem_lat = 3;
        do_reset();
        wait_valid("rd_valid0");
        @(posedge clk);
        #1;
        wait_valid("rd_valid1");
        check_eq("rd_pc1", if_pc, 32'h4);
        @(posedge clk);
        #1;
        check_eq("rd_req_addr", imem_address, 16'h2);
        @(posedge clk);
        #1;
        check_eq("rd_wait_enable", imem_enable, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        check_eq("rd_misaligned", misaligned, 1'b0);
        check_eq("rd_new_addr", imem_address, 16'h40);
        wait_valid("rd_valid2");
        check_eq("rd_pc2", if_pc, 32'h100);

        // Misaligned redirect coinciding with a completed transfer
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        check_eq("mis_pulse", misaligned, 1'b1);
        check_eq("mis_valid_drop", if_valid, 1'b0);
        @(posedge clk);
        #1;
        check_eq("mis_pulse_end", misaligned, 1'b0);
        wait_valid("mis_valid");
        check_eq("mis_pc", if_pc, 32'h100);

        // Randomized handshake, latency and redirects
        mem_lat = -1;
        for (int c = 0; c < 800; c++) begin
            @(posedge clk);
            #1;
            if_ready       = ($urandom % 4) != 0;
            redirect_valid = ($urandom % 12) == 0;
            redirect_pc    = ($urandom % 2 == 1) ? 32'($urandom) : 32'($urandom_range(0, 255));
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        check_eq("rand_progress", xfer_count > 30, 1'b1);

        // Reset asserted in WAIT
        mem_lat = 3;
        do_reset();
        @(posedge clk);
        #1;
        check_eq("rw_wait_enable", imem_enable, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("rw_enable_forced", imem_enable, 1'b0);
        @(posedge clk);
        #1;
        check_eq("rw_valid", if_valid, 1'b0);
        check_eq("rw_enable", imem_enable, 1'b0);
        rst = 1'b0;
        wait_valid("rw_valid_after");
        check_eq("rw_pc", if_pc, 32'h0);

        // Timeout with a ROM that never answers
        mon_en    = 1'b0;
        mem_stall = 1'b1;
        do_reset();
        repeat (16) @(posedge clk);
        #1;
        check_eq("to_not_yet", fetch_error, 1'b0);
        check_eq("to_enable_wait", imem_enable, 1'b1);
        @(posedge clk);
        #1;
        check_eq("to_error", fetch_error, 1'b1);
        check_eq("to_enable_off", imem_enable, 1'b0);
        check_eq("to_valid_off", if_valid, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        check_eq("to_redir_mis", misaligned, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("to_sticky", fetch_error, 1'b1);
        check_eq("to_sticky_enable", imem_enable, 1'b0);
        check_eq("to_sticky_valid", if_valid, 1'b0);
        mem_stall = 1'b0;
        mem_lat   = 0;
        do_reset();
        mon_en = 1'b1;
        wait_valid("to_restart_valid");
        check_eq("to_restart_pc", if_pc, 32'h0);
        check_eq("to_restart_instr", if_instr, 32'h2001_0005);

        // PC wrap on the second instance (reset PC 0xFFFFFFFC)
        do_reset();
        n = 0;
        while (!w_if_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("wrap_valid0", w_if_valid, 1'b1);
        check_eq("wrap_pc0", w_if_pc, 32'hFFFF_FFFC);
        check_eq("wrap_npc0", w_if_npc, 32'h0);
        check_eq("wrap_instr0", w_if_instr, 32'hBEEF_FFFF);
        @(posedge clk);
        #1;
        n = 0;
        while (!w_if_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("wrap_valid1", w_if_valid, 1'b1);
        check_eq("wrap_pc1", w_if_pc, 32'h0);
        check_eq("wrap_npc1", w_if_npc, 32'h4);
        check_eq("wrap_instr1", w_if_instr, 32'hBEEF_0000);
        check_eq("wrap_misaligned", w_misaligned, 1'b0);
        check_eq("wrap_fetch_error", w_fetch_error, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
